// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   W          operand/result width
//   iValid     request present                 (master -> slave)
//   oReady     slave can accept a request      (slave -> master)
//   ctrl       operation select                (master -> slave)
//   data1      operand A                       (master -> slave)
//   data2      operand B / shift amount        (master -> slave)
//   oValid     one-cycle result strobe         (slave -> master)
//   out        result                          (slave -> master)
//   oCarry     carry/borrow/shift-out/mul-ovf  (slave -> master)
//   oZero      out == 0                        (slave -> master)
//   oOverflow  signed overflow                 (slave -> master)
//   oNeg       out[W-1]                        (slave -> master)
interface alu_seq_if #(
    parameter int unsigned W = 32
);
    logic         iValid;
    logic         oReady;
    logic [2:0]   ctrl;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         oValid;
    logic [W-1:0] out;
    logic         oCarry;
    logic         oZero;
    logic         oOverflow;
    logic         oNeg;

    modport master (
        output iValid, ctrl, data1, data2,
        input  oReady, oValid, out, oCarry, oZero, oOverflow, oNeg
    );

    modport slave (
        input  iValid, ctrl, data1, data2,
        output oReady, oValid, out, oCarry, oZero, oOverflow, oNeg
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready request handshake and a one-cycle
// result strobe. Add/sub/logic ops finish in one cycle; shifts move one bit per
// cycle; multiply (optional) adds one partial product per cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave (request, operands, result and flags)
//
// Parameters:
//   W      operand/result width (4..64)
//   SHW    shift-amount width, derived as $clog2(W)
//
// Build option:
//   ALU_SEQ_MUL_EN  when defined, op 111 is a W-cycle shift-add unsigned
//                   multiply; otherwise op 111 returns data1 in one cycle.
module alu_seq #(
    parameter  int unsigned W   = 32,
    localparam int unsigned SHW = $clog2(W)
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);

`ifdef ALU_SEQ_MUL_EN
    // Multiply needs to count to W, one more bit than the largest shift amount.
    localparam int unsigned CntW = SHW + 1;
`else
    localparam int unsigned CntW = SHW;
`endif

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpSra = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    work_q, work_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    out_q, out_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            neg_q, neg_d;

    // Result being registered this edge (only meaningful when res_load is set).
    logic            res_load;
    logic [W-1:0]    res_val;
    logic            res_c;
    logic            res_v;

    logic            accept;
    logic [W:0]      add_full;
    logic [W:0]      sub_full;
    logic            add_ovf;
    logic            sub_ovf;
    logic [SHW-1:0]  shamt;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]    acc_hi_q, acc_hi_d;
    logic [W-1:0]    acc_lo_q, acc_lo_d;
    logic [W:0]      mul_sum;
`endif

    assign accept   = bus.iValid && (state_q != StBusy);
    assign add_full = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign sub_full = {1'b0, bus.data1} - {1'b0, bus.data2};
    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign add_ovf  = (bus.data1[W-1] == bus.data2[W-1]) && (add_full[W-1] != bus.data1[W-1]);
    assign sub_ovf  = (bus.data1[W-1] != bus.data2[W-1]) && (sub_full[W-1] != bus.data1[W-1]);
    assign shamt    = bus.data2[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
    // One partial product per cycle: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole {hi,lo} pair right.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, work_q} : {(W+1){1'b0}});
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        res_load = 1'b0;
        res_val  = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    op_d   = bus.ctrl;
                    work_d = bus.data1;
                    cnt_d  = CntW'(shamt);
                    unique case (bus.ctrl)
                        OpAdd: begin
                            res_load = 1'b1;
                            res_val  = add_full[W-1:0];
                            res_c    = add_full[W];
                            res_v    = add_ovf;
                        end
                        OpSub: begin
                            res_load = 1'b1;
                            res_val  = sub_full[W-1:0];
                            res_c    = sub_full[W];
                            res_v    = sub_ovf;
                        end
                        OpAnd: begin
                            res_load = 1'b1;
                            res_val  = bus.data1 & bus.data2;
                        end
                        OpXor: begin
                            res_load = 1'b1;
                            res_val  = bus.data1 ^ bus.data2;
                        end
                        OpOr: begin
                            res_load = 1'b1;
                            res_val  = bus.data1 | bus.data2;
                        end
                        OpShl, OpSra: begin
                            if (shamt == '0) begin
                                res_load = 1'b1;
                                res_val  = bus.data1;
                            end else begin
                                state_d = StBusy;
                            end
                        end
                        OpMul: begin
`ifdef ALU_SEQ_MUL_EN
                            acc_hi_d = '0;
                            acc_lo_d = bus.data2;
                            cnt_d    = CntW'(W);
                            state_d  = StBusy;
`else
                            res_load = 1'b1;
                            res_val  = bus.data1;
`endif
                        end
                        default: ;
                    endcase
                    if (res_load) begin
                        state_d = StDone;
                    end
                end
            end

            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                unique case (op_q)
                    OpShl: begin
                        work_d = {work_q[W-2:0], 1'b0};
                        res_c  = work_q[W-1];
                    end
                    OpSra: begin
                        work_d = {work_q[W-1], work_q[W-1:1]};
                        res_c  = work_q[0];
                    end
`ifdef ALU_SEQ_MUL_EN
                    OpMul: begin
                        acc_hi_d = mul_sum[W:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
                        res_c    = |mul_sum[W:1];
                        res_v    = |mul_sum[W:1];
                    end
`endif
                    default: ;
                endcase
                // Last iteration: commit the freshly computed value.
                if (cnt_q == CntW'(1)) begin
                    state_d  = StDone;
                    res_load = 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    res_val  = (op_q == OpMul) ? {mul_sum[0], acc_lo_q[W-1:1]} : work_d;
`else
                    res_val  = work_d;
`endif
                end
            end

            default: state_d = StIdle;
        endcase

        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        if (res_load) begin
            out_d   = res_val;
            carry_d = res_c;
            zero_d  = (res_val == '0);
            ovf_d   = res_v;
            neg_d   = res_val[W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end
`endif

    assign bus.oReady    = (state_q != StBusy);
    assign bus.oValid    = (state_q == StDone);
    assign bus.out       = out_q;
    assign bus.oCarry    = carry_q;
    assign bus.oZero     = zero_q;
    assign bus.oOverflow = ovf_q;
    assign bus.oNeg      = neg_q;

endmodule
